// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, state and flag definitions for the sequential ALU
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Bit positions inside the {overflow, negative, carry, zero} flag vector
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;

    // done is held for exactly one cycle: the core consumes the product and busy drops
    assign done_o    = busy_q && (count_q == CW'(WIDTH));
    assign product_o = prod_q;

    // Load on start, then add the shifted multiplicand whenever the current multiplier LSB is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q && !done_o) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
        end else if (done_o) begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered ALU with valid/ready handshakes and a multi-cycle MUL
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [3:0]         out_flags
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [SHW-1:0]     sh;

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == S_OUT);
    assign out_result = result_q;
    assign out_flags  = flags_q;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle datapath; the extra bit in each wide term carries the carry/borrow/shifted-out bit
    always_comb begin
        sh    = in_b[SHW-1:0];
        add_w = {1'b0, in_a} + {1'b0, in_b};
        sub_w = {1'b0, in_a} - {1'b0, in_b};
        shl_w = {1'b0, in_a} << sh;
        shr_w = {in_a, 1'b0} >> sh;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_e'(in_op))
            OP_ADD: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: alu_r = in_a & in_b;
            OP_OR:  alu_r = in_a | in_b;
            OP_XOR: alu_r = in_a ^ in_b;
            OP_SHL: begin
                alu_r = shl_w[WIDTH-1:0];
                alu_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_r = shr_w[WIDTH:1];
                alu_c = shr_w[0];
            end
            default: begin
                alu_r = '0;
                alu_c = 1'b0;
            end
        endcase
    end

    // Next state, result capture and MUL launch; OUT with out_ready behaves like IDLE for accepts
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE, S_OUT: begin
                if (accept) begin
                    if (op_e'(in_op) == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        result_d         = {{WIDTH{1'b0}}, alu_r};
                        flags_d[FLG_Z]   = (alu_r == '0);
                        flags_d[FLG_C]   = alu_c;
                        flags_d[FLG_N]   = alu_r[WIDTH-1];
                        flags_d[FLG_V]   = alu_v;
                        state_d          = S_OUT;
                    end
                end else if (state_q == S_OUT && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    result_d       = mul_product;
                    flags_d[FLG_Z] = (mul_product == '0);
                    flags_d[FLG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLG_N] = mul_product[2*WIDTH-1];
                    flags_d[FLG_V] = 1'b0;
                    state_d        = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - directed and randomized checks of alu_seq_core against a reference model
module tb_alu_seq_core;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] out_result;
    logic [3:0]    out_flags;

    int n_vec = 0;
    int n_err = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: returns {V,N,C,Z, result[15:0]} from plain integer arithmetic
    function automatic logic [19:0] ref_op(input int op, input int a, input int b);
        int r, c, v, n, s;
        logic [31:0] rv;
        c = 0; v = 0;
        s = b % W;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) / 256;
                     v = ((a / 128) == (b / 128)) && ((r / 128) != (a / 128)); end
            1: begin r = (a - b + 256) % 256; c = (a < b);
                     v = ((a / 128) != (b / 128)) && ((r / 128) != (a / 128)); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * (1 << s)) % 256; c = (s == 0) ? 0 : ((a / (1 << (W - s))) % 2); end
            6: begin r = a / (1 << s); c = (s == 0) ? 0 : ((a / (1 << (s - 1))) % 2); end
            default: begin r = a * b; c = (r > 255); end
        endcase
        n = (op == 7) ? (r / 32768) % 2 : (r / 128) % 2;
        rv = r;
        return {v[0], n[0], c[0], (r == 0), rv[15:0]};
    endfunction

    // Behavioural model: a result is either pending (countdown for MUL), presented, or absent
    bit          m_valid;
    logic [19:0] m_out;
    logic [19:0] m_pend;
    int          m_mul_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_out      <= '0;
            m_mul_left <= 0;
        end else if (m_mul_left > 0) begin
            m_mul_left <= m_mul_left - 1;
            if (m_mul_left == 1) begin
                m_valid <= 1'b1;
                m_out   <= m_pend;
            end
        end else begin
            if (m_valid && out_ready) m_valid <= 1'b0;
            if (in_valid && (!m_valid || out_ready)) begin
                if (in_op == 3'd7) begin
                    m_valid    <= 1'b0;
                    m_pend     <= ref_op(7, int'(in_a), int'(in_b));
                    m_mul_left <= W + 1;
                end else begin
                    m_valid <= 1'b1;
                    m_out   <= ref_op(int'(in_op), int'(in_a), int'(in_b));
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, (m_mul_left == 0) && (!m_valid || out_ready)});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out_result", {16'd0, out_result}, {16'd0, m_out[15:0]});
            check("out_flags", {28'd0, out_flags}, {28'd0, m_out[19:16]});
        end
    end

    // Present an op and hold it until accepted; returns just after the accept edge
    task automatic issue(input int op, input int a, input int b);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_op = op[2:0];
        in_a = a[W-1:0];
        in_b = b[W-1:0];
        guard = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    int lat;
    int low_rdy;

    initial begin
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, out_result}, 32'd0);
        check("rst_flags", {28'd0, out_flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed expectations
        out_ready = 1'b1;
        issue(0, 8'hFF, 8'h01);
        @(negedge clk);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_res", {16'd0, out_result}, 32'h0000);
        check("add_flg", {28'd0, out_flags}, 32'b0011);
        @(posedge clk); #1;
        issue(1, 8'h80, 8'h01);
        @(negedge clk);
        check("sub1_res", {16'd0, out_result}, 32'h007F);
        check("sub1_flg", {28'd0, out_flags}, 32'b1000);
        @(posedge clk); #1;
        issue(1, 8'h01, 8'h02);
        @(negedge clk);
        check("sub2_res", {16'd0, out_result}, 32'h00FF);
        check("sub2_flg", {28'd0, out_flags}, 32'b0110);
        @(posedge clk); #1;

        issue(7, 8'hFF, 8'hFF);
        lat = 0; low_rdy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            if (!in_ready) low_rdy++;
        end
        check("mul_latency", lat, 32'd9);
        check("mul_ready_low", low_rdy, 32'd9);
        check("mul_res", {16'd0, out_result}, 32'hFE01);
        check("mul_flg", {28'd0, out_flags}, 32'b0110);
        @(posedge clk); #1;

        issue(5, 8'h81, 8'h01);
        @(negedge clk);
        check("shl_res", {16'd0, out_result}, 32'h0002);
        check("shl_flg", {28'd0, out_flags}, 32'b0010);
        @(posedge clk); #1;
        issue(6, 8'h81, 8'h00);
        @(negedge clk);
        check("shr_res", {16'd0, out_result}, 32'h0081);
        check("shr_flg", {28'd0, out_flags}, 32'b0100);
        @(posedge clk); #1;

        // Backpressure, then retire-and-accept in the same cycle
        out_ready = 1'b0;
        issue(2, 8'hF0, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res", {16'd0, out_result}, 32'h0030);
            check("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4, 8'hF0, 8'h3C);
        @(negedge clk);
        check("xor_valid", {31'd0, out_valid}, 32'd1);
        check("xor_res", {16'd0, out_result}, 32'h00CC);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a MUL
        issue(7, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_res", {16'd0, out_result}, 32'd0);
        check("arst_flg", {28'd0, out_flags}, 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        issue(0, 8'h02, 8'h03);
        @(negedge clk);
        check("post_rst_add", {16'd0, out_result}, 32'h0005);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
